// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the memory-port arbiter: FSM state codes and owner ids.
package mem_port_arbiter_pkg;

  localparam int ARB_STATE_WIDTH = 2;

  localparam logic [ARB_STATE_WIDTH-1:0] ARB_STATE_IDLE = 2'd0;
  localparam logic [ARB_STATE_WIDTH-1:0] ARB_STATE_REQ  = 2'd1;
  localparam logic [ARB_STATE_WIDTH-1:0] ARB_STATE_RESP = 2'd2;

  localparam logic ARB_OWNER_I = 1'b0;
  localparam logic ARB_OWNER_D = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_rr.sv
// Two-way round-robin arbiter: req[0] is instruction fetch, req[1] is data.
// On a tie the side that did not own the previous grant wins.
module rr_arbiter2
  import mem_port_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] grant
);

  logic last_owner_q;
  logic last_owner_d;

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = (last_owner_q == ARB_OWNER_D) ? 2'b01 : 2'b10;
    end
  end

  always_comb begin
    last_owner_d = last_owner_q;
    if (en && (grant != 2'b00)) begin
      last_owner_d = grant[1] ? ARB_OWNER_D : ARB_OWNER_I;
    end
  end

  // Reset to D so that instruction fetch wins the very first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_owner_q <= ARB_OWNER_D;
    end else begin
      last_owner_q <= last_owner_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares a single non-pipelined memory port between instruction fetch and data
// access; one transaction in flight, response routed back to its issuer.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_req_valid,
  output logic                    i_req_ready,
  input  logic [ADDR_WIDTH-1:0]   i_req_addr,
  output logic                    i_resp_valid,
  output logic [DATA_WIDTH-1:0]   i_resp_data,
  input  logic                    d_req_valid,
  output logic                    d_req_ready,
  input  logic                    d_req_we,
  input  logic [ADDR_WIDTH-1:0]   d_req_addr,
  input  logic [DATA_WIDTH-1:0]   d_req_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_req_strobe,
  output logic                    d_resp_valid,
  output logic [DATA_WIDTH-1:0]   d_resp_data,
  output logic                    m_req_valid,
  input  logic                    m_req_ready,
  output logic                    m_req_we,
  output logic [ADDR_WIDTH-1:0]   m_req_addr,
  output logic [DATA_WIDTH-1:0]   m_req_wdata,
  output logic [DATA_WIDTH/8-1:0] m_req_strobe,
  input  logic                    m_resp_valid,
  input  logic [DATA_WIDTH-1:0]   m_resp_data,
  output logic                    spurious_resp
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [ARB_STATE_WIDTH-1:0] state_q, state_d;
  logic                       owner_q, owner_d;
  logic                       we_q, we_d;
  logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
  logic [DATA_WIDTH-1:0]      wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0]      strobe_q, strobe_d;
  logic                       spurious_q, spurious_d;

  logic [1:0] grant;
  logic       grant_en;
  logic       resp_fire;

  rr_arbiter2 u_rr (
    .clk   (clk),
    .rst   (rst),
    .req   ({d_req_valid, i_req_valid}),
    .en    (grant_en),
    .grant (grant)
  );

  // A transfer happens on a rising edge where valid and ready are both high;
  // ready never waits on anything but the FSM being idle, and a requester may
  // withdraw valid at any time before that edge without side effects.
  always_comb begin
    i_req_ready = rst && (state_q == ARB_STATE_IDLE) && grant[0];
    d_req_ready = rst && (state_q == ARB_STATE_IDLE) && grant[1];
    grant_en    = i_req_ready || d_req_ready;
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    strobe_d   = strobe_q;
    spurious_d = spurious_q || (m_resp_valid && (state_q != ARB_STATE_RESP));
    case (state_q)
      ARB_STATE_IDLE: begin
        if (i_req_ready) begin
          owner_d  = ARB_OWNER_I;
          we_d     = 1'b0;
          addr_d   = i_req_addr;
          wdata_d  = '0;
          strobe_d = '1;
          state_d  = ARB_STATE_REQ;
        end else if (d_req_ready) begin
          owner_d  = ARB_OWNER_D;
          we_d     = d_req_we;
          addr_d   = d_req_addr;
          wdata_d  = d_req_wdata;
          strobe_d = d_req_strobe;
          state_d  = ARB_STATE_REQ;
        end
      end
      ARB_STATE_REQ: begin
        if (m_req_ready) state_d = ARB_STATE_RESP;
      end
      ARB_STATE_RESP: begin
        if (m_resp_valid) state_d = ARB_STATE_IDLE;
      end
      default: state_d = ARB_STATE_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ARB_STATE_IDLE;
      owner_q    <= ARB_OWNER_I;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      strobe_q   <= '0;
      spurious_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      strobe_q   <= strobe_d;
      spurious_q <= spurious_d;
    end
  end

  // Memory payload comes only from the latches so it is stable while stalled.
  always_comb begin
    m_req_valid  = (state_q == ARB_STATE_REQ);
    m_req_we     = we_q;
    m_req_addr   = addr_q;
    m_req_wdata  = wdata_q;
    m_req_strobe = strobe_q;
  end

  always_comb begin
    resp_fire     = (state_q == ARB_STATE_RESP) && m_resp_valid;
    i_resp_valid  = resp_fire && (owner_q == ARB_OWNER_I);
    d_resp_valid  = resp_fire && (owner_q == ARB_OWNER_D);
    i_resp_data   = i_resp_valid ? m_resp_data : '0;
    d_resp_data   = (d_resp_valid && !we_q) ? m_resp_data : '0;
    spurious_resp = spurious_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: transaction-level reference model,
// randomized requesters and memory, plus directed latency/reset scenarios.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_req_valid, i_req_ready;
  logic [AW-1:0] i_req_addr;
  logic          i_resp_valid;
  logic [DW-1:0] i_resp_data;
  logic          d_req_valid, d_req_ready, d_req_we;
  logic [AW-1:0] d_req_addr;
  logic [DW-1:0] d_req_wdata;
  logic [SW-1:0] d_req_strobe;
  logic          d_resp_valid;
  logic [DW-1:0] d_resp_data;
  logic          m_req_valid, m_req_ready, m_req_we;
  logic [AW-1:0] m_req_addr;
  logic [DW-1:0] m_req_wdata;
  logic [SW-1:0] m_req_strobe;
  logic          m_resp_valid;
  logic [DW-1:0] m_resp_data;
  logic          spurious_resp;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
    .i_resp_valid(i_resp_valid), .i_resp_data(i_resp_data),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_we(d_req_we),
    .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata), .d_req_strobe(d_req_strobe),
    .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_we(m_req_we),
    .m_req_addr(m_req_addr), .m_req_wdata(m_req_wdata), .m_req_strobe(m_req_strobe),
    .m_resp_valid(m_resp_valid), .m_resp_data(m_resp_data),
    .spurious_resp(spurious_resp)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
  endtask

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic          owner;   // 0 = instruction, 1 = data
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] strobe;
  } txn_t;

  txn_t          exp_req_q[$];   // granted, waiting for the memory to accept
  txn_t          inflight_q[$];  // accepted by memory, waiting for its response
  logic [DW:0]   exp_q[$];       // {owner, data} expected on the response side
  logic          grant_log[$];

  // Transaction-level reference state
  bit   busy_m  = 0;  // a transaction is owned by the port
  bit   mreq_m  = 0;  // memory request should be presented
  bit   await_m = 0;  // memory has accepted and owes a response
  bit   spur_m  = 0;
  logic last_m  = 1'b1;

  // Memory model knobs (negative delay = random 0..3)
  bit            mem_en     = 1;
  int            ready_dly  = -1;
  int            resp_dly   = -1;
  bit            data_fixed = 0;
  logic [DW-1:0] data_val   = '0;

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin : monitor
    bit          pb, pm, pa, gi, gd;
    txn_t        t;
    logic [DW:0] r;
    if (!rst) begin
      check("reset_outputs_a",
            {i_req_ready, d_req_ready, i_resp_valid, i_resp_data, d_resp_valid, d_resp_data, m_req_valid, spurious_resp}, '0);
      check("reset_outputs_b", {m_req_we, m_req_addr, m_req_wdata, m_req_strobe}, '0);
      exp_req_q.delete(); inflight_q.delete(); exp_q.delete();
      busy_m = 0; mreq_m = 0; await_m = 0; spur_m = 0; last_m = 1'b1;
    end else begin
      pb = busy_m; pm = mreq_m; pa = await_m;
      check("spurious_resp", spurious_resp, spur_m);

      gi = 0; gd = 0;
      if (!pb) begin
        if (i_req_valid && d_req_valid) begin
          gi = last_m; gd = !last_m;
        end else begin
          gi = i_req_valid; gd = d_req_valid;
        end
      end
      check("req_ready", {i_req_ready, d_req_ready}, {gi, gd});
      if (gi || gd) begin
        t.owner  = gd;
        t.we     = gd ? d_req_we : 1'b0;
        t.addr   = gd ? d_req_addr : i_req_addr;
        t.wdata  = gd ? d_req_wdata : '0;
        t.strobe = gd ? d_req_strobe : '1;
        exp_req_q.push_back(t);
        grant_log.push_back(gd);
        last_m = gd; busy_m = 1; mreq_m = 1;
      end

      check("m_req_valid", m_req_valid, pm);
      if (pm && exp_req_q.size() > 0) begin
        t = exp_req_q[0];
        check("m_req_payload", {m_req_we, m_req_addr, m_req_wdata, m_req_strobe},
              {t.we, t.addr, t.wdata, t.strobe});
      end
      if (pm && m_req_ready) begin
        if (exp_req_q.size() > 0) inflight_q.push_back(exp_req_q.pop_front());
        mreq_m = 0; await_m = 1;
      end

      if (m_resp_valid) begin
        if (pa) begin busy_m = 0; await_m = 0; end
        else spur_m = 1;
      end

      if (i_resp_valid || d_resp_valid || exp_q.size() > 0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_resp", {i_resp_valid, d_resp_valid}, 2'b00);
        end else begin
          r = exp_q.pop_front();
          check("resp", {i_resp_valid, d_resp_valid, (r[DW] ? d_resp_data : i_resp_data)},
                {!r[DW], r[DW], r[DW-1:0]});
        end
      end
    end
  end

  // ---------------- memory model ----------------
  initial begin : mem_model
    bit   counting, busy;
    int   rw, sw;
    txn_t t;
    m_req_ready = 1'b0; m_resp_valid = 1'b0; m_resp_data = '0;
    counting = 0; busy = 0; rw = 0; sw = 0;
    forever begin
      @(posedge clk); #1;
      if (!mem_en) begin
        counting = 0; busy = 0;
      end else if (!rst) begin
        counting = 0; busy = 0; m_req_ready = 1'b0; m_resp_valid = 1'b0;
      end else begin
        m_req_ready = 1'b0; m_resp_valid = 1'b0;
        if (busy) begin
          if (sw == 0) begin
            busy = 0;
            m_resp_valid = 1'b1;
            m_resp_data  = data_fixed ? data_val : $urandom;
            if (inflight_q.size() > 0) begin
              t = inflight_q.pop_front();
              exp_q.push_back({t.owner, (t.we ? {DW{1'b0}} : m_resp_data)});
            end
          end else sw--;
        end else if (m_req_valid) begin
          if (!counting) begin
            counting = 1;
            if (ready_dly < 0) rw = int'($urandom_range(0, 3)); else rw = ready_dly;
          end
          if (rw == 0) begin
            m_req_ready = 1'b1; counting = 0; busy = 1;
            if (resp_dly < 0) sw = int'($urandom_range(0, 3)); else sw = resp_dly;
          end else rw--;
        end
      end
    end
  end

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic issue_i(input logic [AW-1:0] addr, input int patience);
    int waited = 0;
    bit got    = 0;
    i_req_addr  = addr;
    i_req_valid = 1'b1;
    while (!got) begin
      @(negedge clk); got = i_req_ready;
      @(posedge clk); #1;
      waited++;
      if (!got && patience >= 0 && waited > patience) break;
      if (!got && waited > 400) begin check("i_req_timeout", 1'b0, 1'b1); break; end
    end
    i_req_valid = 1'b0;
  endtask

  task automatic issue_d(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input logic [SW-1:0] strobe, input int patience);
    int waited = 0;
    bit got    = 0;
    d_req_we = we; d_req_addr = addr; d_req_wdata = wdata; d_req_strobe = strobe;
    d_req_valid = 1'b1;
    while (!got) begin
      @(negedge clk); got = d_req_ready;
      @(posedge clk); #1;
      waited++;
      if (!got && patience >= 0 && waited > patience) break;
      if (!got && waited > 400) begin check("d_req_timeout", 1'b0, 1'b1); break; end
    end
    d_req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy_m || exp_q.size() != 0) && n < 200) begin @(negedge clk); n++; end
    if (busy_m) check("idle_timeout", busy_m, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic check_grants(input string name, input int base, input int n, input logic [15:0] exp);
    logic [15:0] act = '0;
    for (int i = 0; i < n; i++) act[i] = (base + i < grant_log.size()) ? grant_log[base + i] : 1'bx;
    check(name, act, exp);
  endtask

  function automatic int rand_patience();
    if ($urandom_range(0, 4) == 0) return int'($urandom_range(0, 2));
    return -1;
  endfunction

  // ---------------- main sequence ----------------
  initial begin : main
    int base;
    i_req_valid = 0; i_req_addr = '0;
    d_req_valid = 0; d_req_we = 0; d_req_addr = '0; d_req_wdata = '0; d_req_strobe = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("reset_state", {m_req_valid, spurious_resp, i_req_ready, d_req_ready, m_req_addr, m_req_strobe}, '0);

    // Single instruction fetch, fastest memory
    ready_dly = 0; resp_dly = 0; data_fixed = 1; data_val = 32'hDEADBEEF;
    @(posedge clk); #1;
    i_req_valid = 1'b1; i_req_addr = 32'h100;
    @(negedge clk);
    check("t1_ready_c0", {i_req_ready, d_req_ready}, 2'b10);
    @(posedge clk); #1;
    i_req_valid = 1'b0;
    @(negedge clk);
    check("t1_mreq_c1", {m_req_valid, m_req_we, m_req_addr, m_req_strobe}, {1'b1, 1'b0, 32'h100, 4'hF});
    @(posedge clk); #1;
    @(negedge clk);
    check("t1_resp_c2", {i_resp_valid, d_resp_valid, i_resp_data}, {2'b10, 32'hDEADBEEF});
    data_fixed = 0;
    wait_idle();

    // Simultaneous requests from reset: instruction first, then the store
    apply_reset();
    ready_dly = -1; resp_dly = -1;
    base = grant_log.size();
    fork
      issue_i($urandom, -1);
      issue_d(1'b1, 32'h200, 32'h55, 4'h3, -1);
    join
    wait_idle();
    check_grants("t2_order", base, 2, 16'b10);

    // Six back-to-back contended grants alternate
    base = grant_log.size();
    fork
      begin repeat (3) issue_i($urandom, -1); end
      begin repeat (3) issue_d(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)), -1); end
    join
    wait_idle();
    check_grants("t3_alternate", base, 6, 16'b101010);

    // Memory stalls for 4 cycles while the data inputs keep changing
    ready_dly = 4; resp_dly = 1;
    d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 32'h300; d_req_wdata = $urandom; d_req_strobe = 4'hA;
    @(negedge clk);
    check("t4_grant", {i_req_ready, d_req_ready}, 2'b01);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      d_req_valid = 1'b0; d_req_addr = $urandom; d_req_wdata = $urandom;
      @(negedge clk);
      check("t4_hold", {m_req_valid, m_req_ready, m_req_addr}, {2'b10, 32'h300});
    end
    @(posedge clk); #1;
    @(negedge clk);
    check("t4_accept", {m_req_valid, m_req_ready}, 2'b11);
    @(posedge clk); #1;
    @(negedge clk);
    check("t4_left_req", m_req_valid, 1'b0);
    wait_idle();

    // Randomized traffic with abandoning requesters and random memory timing
    ready_dly = -1; resp_dly = -1;
    fork
      begin
        for (int k = 0; k < 50; k++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          issue_i($urandom, rand_patience());
        end
      end
      begin
        for (int k = 0; k < 50; k++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          issue_d(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)), rand_patience());
        end
      end
    join
    wait_idle();

    // Reset while a response is owed, then a late memory response
    ready_dly = 0; resp_dly = 5;
    i_req_valid = 1'b1; i_req_addr = $urandom;
    @(posedge clk); #1;
    i_req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_en = 0; m_req_ready = 1'b0; m_resp_valid = 1'b0;
    i_req_valid = 1'b1; d_req_valid = 1'b1;
    rst = 1'b0;
    #1;
    check("t5_async_zero_a", {i_req_ready, d_req_ready, i_resp_valid, d_resp_valid, m_req_valid, spurious_resp}, '0);
    check("t5_async_zero_b", {m_req_we, m_req_addr, m_req_wdata, m_req_strobe}, '0);
    repeat (2) begin @(posedge clk); #1; end
    i_req_valid = 1'b0; d_req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    m_resp_valid = 1'b1; m_resp_data = $urandom;
    @(negedge clk);
    check("t5_late_resp_dropped", {i_resp_valid, d_resp_valid}, 2'b00);
    @(posedge clk); #1;
    m_resp_valid = 1'b0;
    @(negedge clk);
    check("t5_spurious", spurious_resp, 1'b1);
    mem_en = 1; ready_dly = -1; resp_dly = -1;
    @(posedge clk); #1;
    base = grant_log.size();
    fork
      issue_i($urandom, -1);
      issue_d(1'b0, $urandom, $urandom, 4'hF, -1);
    join
    wait_idle();
    check_grants("t5_i_first", base, 2, 16'b10);

    // Stray memory response while idle
    apply_reset();
    mem_en = 0; m_req_ready = 1'b0; m_resp_valid = 1'b0;
    @(posedge clk); #1;
    m_resp_valid = 1'b1; m_resp_data = $urandom;
    @(negedge clk);
    check("t6_no_resp", {i_resp_valid, d_resp_valid}, 2'b00);
    check("t6_spur_not_yet", spurious_resp, 1'b0);
    @(posedge clk); #1;
    m_resp_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t6_spur_sticky", spurious_resp, 1'b1);
      @(posedge clk); #1;
    end
    mem_en = 1;

    repeat (3) @(posedge clk);
    check("queues_drained", {32'(exp_req_q.size()), 32'(inflight_q.size()), 32'(exp_q.size())}, '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    n_fail++;
    $display("FAIL watchdog: run did not complete, checks=%0d", n_checks);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the core's single memory port between the instruction-fetch requester (driven by the control unit's inst_fetch path) and the data requester (load_data/store_data path).
- Non-pipelined: one transaction outstanding at a time.
- Arbitration is round-robin when both sides request in the same cycle.
- Routes the memory response back to the requester that issued the transaction; writes also receive a response (ack).

Parameters:
ADDR_WIDTH, 32, address width of all request channels
DATA_WIDTH, 32, data width; strobe width = DATA_WIDTH/8 (derived localparam, DATA_WIDTH multiple of 8)

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  reset, asynchronous, active-low
i_req_valid  input  1  instruction read request
i_req_ready  output  1  instruction request accepted this cycle
i_req_addr  input  ADDR_WIDTH  instruction address
i_resp_valid  output  1  instruction read data valid (1-cycle pulse)
i_resp_data  output  DATA_WIDTH  instruction read data
d_req_valid  input  1  data request
d_req_ready  output  1  data request accepted this cycle
d_req_we  input  1  1=store, 0=load
d_req_addr  input  ADDR_WIDTH  data address
d_req_wdata  input  DATA_WIDTH  store data
d_req_strobe  input  DATA_WIDTH/8  store byte enables
d_resp_valid  output  1  load data / store ack valid (1-cycle pulse)
d_resp_data  output  DATA_WIDTH  load data (0 for store ack)
m_req_valid  output  1  memory request valid
m_req_ready  input  1  memory accepts request
m_req_we  output  1  write enable
m_req_addr  output  ADDR_WIDTH  memory address
m_req_wdata  output  DATA_WIDTH  write data
m_req_strobe  output  DATA_WIDTH/8  byte enables (all-ones for instruction reads)
m_resp_valid  input  1  memory response valid; no backpressure
m_resp_data  input  DATA_WIDTH  memory read data
spurious_resp  output  1  sticky: m_resp_valid seen outside RESP

Behaviour:
- Reset (rst=0, async):
  - State=IDLE, last_owner=D (instruction wins first tie).
  - Latched request registers cleared.
  - All outputs 0, spurious_resp=0.
  - Outstanding transaction dropped; any later m_resp_valid sets spurious_resp.
- States IDLE, REQ, RESP.
- IDLE:
  - Winner: only one valid -> that side. Both valid -> side != last_owner.
  - Winner's *_req_ready=1 combinationally in the same cycle; the other side's ready=0.
  - On handshake: latch we/addr/wdata/strobe and owner, update last_owner, go to REQ.
  - Instruction latch forces we=0, strobe all-ones, wdata=0.
  - No valid -> stay in IDLE.
- REQ:
  - m_req_valid=1; m_req_* driven only from registers, stable until m_req_ready.
  - m_req_ready=1 -> RESP, m_req_valid=0 next cycle.
  - Both *_req_ready=0.
- RESP:
  - Wait for m_resp_valid.
  - On that cycle, owner's *_resp_valid=1 combinationally and *_resp_data=m_resp_data (d_resp_data=0 if we=1); go to IDLE.
  - Other side's resp_valid=0.
- Latency:
  - Request handshake -> m_req_valid: 1 cycle.
  - Minimum request-to-response is 3 cycles (m_req_ready=1 and m_resp_valid in the cycle after acceptance).
  - Every transaction spends ≥1 IDLE cycle; there are no back-to-back grants.
- Requester valids may drop without handshake; nothing is latched.
- m_resp_valid in IDLE/REQ: ignored, not forwarded, spurious_resp set until reset.
- m_req_* outside REQ: valid=0, payload holds the last latched value.

Decomposition:
- copperv_h.v gains:
  - ARB_STATE_WIDTH (2)
  - ARB_STATE_IDLE/REQ/RESP (0/1/2)
  - ARB_OWNER_I (0) / ARB_OWNER_D (1)
- One sub-module: rr_arbiter2.
  - Two request bits + last_owner in; one-hot grant out.
  - Registered last_owner update on an enable.
- FSM, latches and response routing stay in mem_port_arbiter.

Test Plan:
- Only i_req_valid, addr=0x100; memory ready immediately, resp 0xDEADBEEF next cycle.
  -> i_req_ready at cycle 0; m_req_valid cycle 1 with addr 0x100, we=0, strobe=0xF; i_resp_valid pulse with 0xDEADBEEF at cycle 2; d_resp_valid stays 0.
- i and d valid together from reset (d: store addr 0x200, wdata 0x55, strobe 0x3), held.
  -> instruction granted first; data granted in the next IDLE.
  -> m_req: we=1, addr 0x200, wdata 0x55, strobe 0x3.
  -> d_resp_valid pulse with data 0.
- Both valid continuously for 6 transactions -> grants alternate I,D,I,D,I,D.
- m_req_ready held 0 for 4 cycles while d_req_addr input changes.
  -> m_req_valid=1 and m_req_addr constant across all 4 cycles; advances to RESP only after ready.
- rst low during RESP, then a late m_resp_valid after release.
  -> all outputs 0 immediately (async); no resp_valid to either side; spurious_resp=1; next i request granted first.
- m_resp_valid pulsed in IDLE -> spurious_resp=1 and stays 1; no resp_valid generated.
